lcb_resp_collector: RTL and testbench



---
 rtl/lcb_resp_collector_pkg.sv | 23 ++
 rtl/lcb_resp_collector_gap.sv | 29 ++
 rtl/lcb_resp_collector.sv | 164 ++++++++++++++++
 tb/tb_lcb_resp_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcb_resp_collector_pkg.sv
// Shared definitions for the LCB response collector: state codes, default timing/fill
// constants and the running-checksum helper.
package lcb_resp_collector_pkg;

  typedef logic [2:0] lcbState_t;

  localparam lcbState_t ST_IDLE = 3'd0;
  localparam lcbState_t ST_WAIT = 3'd1;
  localparam lcbState_t ST_RECV = 3'd2;
  localparam lcbState_t ST_FILL = 3'd3;
  localparam lcbState_t ST_DONE = 3'd4;

  localparam int unsigned DEF_ADDR_W     = 32'd5;
  localparam logic [15:0] DEF_NORESP_CYC = 16'd4000;
  localparam logic [15:0] DEF_GAP_CYC    = 16'd400;
  localparam logic [7:0]  DEF_FILL       = 8'hFF;

  // Mod-256 accumulate used for the response checksum.
  function automatic logic [7:0] sumAdd(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/lcb_resp_collector_gap.sv
// lcb_gap_timer: 16-bit saturating cycle counter with synchronous clear and a
// compare-to-limit flag. The limit is chosen by the instantiating FSM.
module lcb_gap_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] limit,
  output logic        hit
);

  logic [15:0] cntR;

  // Counter: clear wins over count, and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cntR <= 16'd0;
    end else if (clr) begin
      cntR <= 16'd0;
    end else if (en && (cntR != 16'hFFFF)) begin
      cntR <= cntR + 16'd1;
    end else begin
      cntR <= cntR;
    end
  end

  assign hit = (cntR == limit);

endmodule

// File: rtl/lcb_resp_collector.sv
// Per-channel LCB response collector: writes UART bytes into ramUART, pads short frames
// with FILL and pulses full once per request. Optional macro CHECKSUM_EN adds errSum.
module lcb_resp_collector
  import lcb_resp_collector_pkg::*;
#(
  parameter int unsigned BYTES      = 32'd4,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter logic [15:0] NORESP_CYC = DEF_NORESP_CYC,
  parameter logic [15:0] GAP_CYC    = DEF_GAP_CYC,
  parameter logic [7:0]  FILL       = DEF_FILL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              strob,
  input  logic [7:0]        iData,
  output logic [ADDR_W-1:0] wrAdr,
  output logic [7:0]        wrData,
  output logic              WE,
  output logic              full,
  output logic              errNoResp,
  output logic              errShort,
  output logic              stray,
  output logic [ADDR_W:0]   rxCnt
`ifdef CHECKSUM_EN
  ,
  output logic              errSum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BYTES - 32'd1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(32'd1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(32'd1);

  lcbState_t         stateR;
  logic [ADDR_W-1:0] idxR;
  logic              lastWrR;
  logic              liveS;
  logic              timerClrS;
  logic [15:0]       timerLimS;
  logic              timerHitS;
  logic              writeS;
  logic              timeoutS;

  // The timer only runs while waiting for bytes; any accepted byte or arm restarts it.
  assign liveS     = (stateR == ST_WAIT) || (stateR == ST_RECV);
  assign timerClrS = arm || !liveS || strob;
  assign timerLimS = (stateR == ST_WAIT) ? (NORESP_CYC - 16'd1) : (GAP_CYC - 16'd1);
  assign writeS    = !arm && strob && liveS;
  assign timeoutS  = !arm && !strob && liveS && timerHitS;

  lcb_gap_timer uTimer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timerClrS),
    .en    (liveS),
    .limit (timerLimS),
    .hit   (timerHitS)
  );

  // Frame FSM and registered RAM write port; a byte wins over a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateR    <= ST_IDLE;
      idxR      <= '0;
      lastWrR   <= 1'b0;
      wrAdr     <= '0;
      wrData    <= 8'h00;
      WE        <= 1'b0;
      full      <= 1'b0;
      errNoResp <= 1'b0;
      errShort  <= 1'b0;
      stray     <= 1'b0;
      rxCnt     <= '0;
    end else begin
      WE      <= 1'b0;
      stray   <= 1'b0;
      lastWrR <= 1'b0;
      full    <= lastWrR;
      if (arm) begin
        stateR    <= ST_WAIT;
        idxR      <= '0;
        rxCnt     <= '0;
        errNoResp <= 1'b0;
        errShort  <= 1'b0;
      end else begin
        case (stateR)
          ST_IDLE, ST_DONE: begin
            stray <= strob;
          end
          ST_WAIT, ST_RECV: begin
            if (strob) begin
              WE     <= 1'b1;
              wrAdr  <= idxR;
              wrData <= iData;
              rxCnt  <= rxCnt + CNT_ONE;
              if (idxR == LAST_IDX) begin
                lastWrR <= 1'b1;
                stateR  <= ST_DONE;
              end else begin
                idxR   <= idxR + IDX_ONE;
                stateR <= ST_RECV;
              end
            end else if (timerHitS) begin
              if (stateR == ST_WAIT) begin
                errNoResp <= 1'b1;
              end else begin
                errShort <= 1'b1;
              end
              stateR <= ST_FILL;
            end else begin
              stateR <= stateR;
            end
          end
          ST_FILL: begin
            stray  <= strob;
            WE     <= 1'b1;
            wrAdr  <= idxR;
            wrData <= FILL;
            if (idxR == LAST_IDX) begin
              lastWrR <= 1'b1;
              stateR  <= ST_DONE;
            end else begin
              idxR <= idxR + IDX_ONE;
            end
          end
          default: begin
            stateR <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] sumR;
  logic       sumBadR;

  // Payload sum; the final byte's verdict is held one cycle so errSum lands with full.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sumR    <= 8'h00;
      sumBadR <= 1'b0;
      errSum  <= 1'b0;
    end else if (arm) begin
      sumR    <= 8'h00;
      sumBadR <= 1'b0;
      errSum  <= 1'b0;
    end else begin
      sumBadR <= writeS && (idxR == LAST_IDX) && (iData != sumR);
      if (writeS && (idxR != LAST_IDX)) begin
        sumR <= sumAdd(sumR, iData);
      end else begin
        sumR <= sumR;
      end
      errSum <= errSum || sumBadR || timeoutS;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = timeoutS ^ writeS;
`endif

endmodule

// File: tb/tb_lcb_resp_collector.sv
// Directed bench for lcb_resp_collector (BYTES=4): frame table plus hand sequences for
// abort, stray, reset and (with CHECKSUM_EN) checksum cases.
`timescale 1ns/1ps
module tb_lcb_resp_collector;

  localparam int NB     = 4;
  localparam int NORESP = 4000;
  localparam int GAP    = 400;

  typedef struct {
    int          nb;
    logic [31:0] bytes;
    int          gap;
    logic [31:0] expDat;
    logic        expNoResp;
    logic        expShort;
    int          expCnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0;
  logic       strob = 1'b0;
  logic [7:0] iData = 8'h00;
  logic [4:0] wrAdr;
  logic [7:0] wrData;
  logic       WE, full, errNoResp, errShort, stray;
  logic [5:0] rxCnt;
`ifdef CHECKSUM_EN
  logic       errSum;
`endif

  lcb_resp_collector #(.BYTES(NB)) dut (
    .clk(clk), .rst(rst), .arm(arm), .strob(strob), .iData(iData),
    .wrAdr(wrAdr), .wrData(wrData), .WE(WE), .full(full),
    .errNoResp(errNoResp), .errShort(errShort), .stray(stray), .rxCnt(rxCnt)
`ifdef CHECKSUM_EN
    , .errSum(errSum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int armCyc = 0;
  int weAdr[$], weDat[$], weCyc[$], fullCyc[$], fullSum[$];
  int strayCnt = 0;
  int noRespCyc = -1;
  int shortCyc = -1;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (WE === 1'b1) begin
      weAdr.push_back(int'(wrAdr));
      weDat.push_back(int'(wrData));
      weCyc.push_back(cyc);
    end
    if (full === 1'b1) begin
      fullCyc.push_back(cyc);
`ifdef CHECKSUM_EN
      fullSum.push_back(int'(errSum));
`endif
    end
    if (stray === 1'b1) strayCnt++;
    if (errNoResp === 1'b1 && noRespCyc < 0) noRespCyc = cyc;
    if (errShort === 1'b1 && shortCyc < 0) shortCyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearMon();
    weAdr.delete(); weDat.delete(); weCyc.delete(); fullCyc.delete(); fullSum.delete();
    strayCnt = 0; noRespCyc = -1; shortCyc = -1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, output int sc);
    repeat (gap - 1) @(negedge clk);
    strob = 1'b1; iData = b;
    @(negedge clk);
    strob = 1'b0;
    sc = cyc;
  endtask

  task automatic waitFull(input string tag);
    int n = 0;
    while (fullCyc.size() == 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      bad++; total++;
      $display("FAIL %s_timeout: got no full expected full within 6000 cycles", tag);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic runFrame(input vec_t v, input string tag);
    int firstS = -1;
    int lastS = -1;
    int sc;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    clearMon(); armCyc = cyc;
    for (int i = 0; i < v.nb; i++) begin
      sendByte(v.bytes[8*i +: 8], v.gap, sc);
      lastS = sc;
      if (i == 0) firstS = sc;
    end
    waitFull(tag);
    chk({tag, "_nfull"}, fullCyc.size(), 1);
    chk({tag, "_nwr"}, weAdr.size(), NB);
    for (int i = 0; i < NB && i < weAdr.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), weAdr[i], i);
      chk($sformatf("%s_dat%0d", tag, i), weDat[i], v.expDat[8*i +: 8]);
    end
    if (fullCyc.size() > 0 && weCyc.size() > 0)
      chk({tag, "_fullLat"}, fullCyc[0], weCyc[weCyc.size()-1] + 1);
    chk({tag, "_errNoResp"}, errNoResp, v.expNoResp);
    chk({tag, "_errShort"}, errShort, v.expShort);
    chk({tag, "_rxCnt"}, rxCnt, v.expCnt);
    chk({tag, "_stray"}, strayCnt, 0);
    if (firstS >= 0 && weCyc.size() > 0) chk({tag, "_wrLat"}, weCyc[0], firstS);
    if (v.expNoResp) begin
      chk({tag, "_noRespTime"}, noRespCyc - armCyc, NORESP);
      if (weCyc.size() == NB) begin
        chk({tag, "_fill0Time"}, weCyc[0], noRespCyc + 1);
        chk({tag, "_fill3Time"}, weCyc[NB-1], noRespCyc + NB);
      end
    end
    if (v.expShort) begin
      chk({tag, "_shortTime"}, shortCyc - lastS, GAP);
      if (weCyc.size() > v.nb) chk({tag, "_fillStart"}, weCyc[v.nb], shortCyc + 1);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    vec_t cv;
    vecs[0] = '{4, 32'h44332211, 200, 32'h44332211, 1'b0, 1'b0, 4};
    vecs[1] = '{0, 32'h00000000, 1,   32'hFFFFFFFF, 1'b1, 1'b0, 0};
    vecs[2] = '{4, 32'hEFBEADDE, 1,   32'hEFBEADDE, 1'b0, 1'b0, 4};
    vecs[3] = '{1, 32'h000000C3, 1,   32'hFFFFFFC3, 1'b0, 1'b1, 1};
    vecs[4] = '{3, 32'h00030201, 300, 32'hFF030201, 1'b0, 1'b1, 3};
    vecs[5] = '{2, 32'h00005AA5, 10,  32'hFFFF5AA5, 1'b0, 1'b1, 2};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wrAdr", wrAdr, 0);
    chk("rst_wrData", wrData, 0);
    chk("rst_WE", WE, 0);
    chk("rst_full", full, 0);
    chk("rst_errs", {errNoResp, errShort}, 0);
    chk("rst_stray", stray, 0);
    chk("rst_rxCnt", rxCnt, 0);
    rst = 1'b1;
    @(negedge clk);

    strob = 1'b1; iData = 8'h5C;
    @(negedge clk);
    strob = 1'b0;
    chk("idle_stray", stray, 1);
    chk("idle_noWE", WE, 0);
    @(negedge clk);
    chk("idle_strayPulse", stray, 0);

    for (int k = 0; k < 6; k++) runFrame(vecs[k], $sformatf("v%0d", k));

    // Abort mid-frame with arm+strob together; previous frame left errShort set.
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    clearMon();
    chk("abort_errClr", {errNoResp, errShort}, 0);
    sendByte(8'h77, 1, sc);
    repeat (2) @(negedge clk);
    arm = 1'b1; strob = 1'b1; iData = 8'h99;
    @(negedge clk);
    arm = 1'b0; strob = 1'b0;
    chk("armStrob_WE", WE, 0);
    chk("armStrob_stray", stray, 0);
    chk("armStrob_rxCnt", rxCnt, 0);
    sendByte(8'h10, 3, sc);
    sendByte(8'h20, 3, sc);
    sendByte(8'h30, 3, sc);
    sendByte(8'h40, 3, sc);
    waitFull("abort");
    chk("abort_nwr", weAdr.size(), 5);
    if (weAdr.size() == 5) begin
      chk("abort_adr0", weAdr[0], 0);
      chk("abort_dat0", weDat[0], 8'h77);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("abort_adr%0d", i + 1), weAdr[i+1], i);
        chk($sformatf("abort_dat%0d", i + 1), weDat[i+1], (i + 1) * 16);
      end
    end
    chk("abort_nfull", fullCyc.size(), 1);
    chk("abort_rxCnt", rxCnt, 4);
    chk("abort_stray", strayCnt, 0);

    strob = 1'b1; iData = 8'hAB;
    @(negedge clk);
    strob = 1'b0;
    chk("done_stray", stray, 1);
    chk("done_noWE", WE, 0);
    chk("done_rxCnt", rxCnt, 4);

`ifdef CHECKSUM_EN
    cv = '{4, 32'h06030201, 5, 32'h06030201, 1'b0, 1'b0, 4};
    runFrame(cv, "sumOk");
    if (fullSum.size() > 0) chk("sumOk_errSum", fullSum[0], 0);
    cv = '{4, 32'h07030201, 5, 32'h07030201, 1'b0, 1'b0, 4};
    runFrame(cv, "sumBad");
    if (fullSum.size() > 0) chk("sumBad_errSumAtFull", fullSum[0], 1);
    chk("sumBad_sticky", errSum, 1);
`else
    cv = vecs[0];
`endif

    // Reset in the middle of a frame.
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    sendByte(8'h55, 5, sc);
    sendByte(8'h66, 5, sc);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midRst_wrAdr", wrAdr, 0);
    chk("midRst_wrData", wrData, 0);
    chk("midRst_WE", WE, 0);
    chk("midRst_flags", {full, errNoResp, errShort, stray}, 0);
    chk("midRst_rxCnt", rxCnt, 0);
`ifdef CHECKSUM_EN
    chk("midRst_errSum", errSum, 0);
`endif
    clearMon();
    repeat (NORESP + 100) @(negedge clk);
    chk("midRst_idleNoTimeout", errNoResp, 0);
    chk("midRst_noWrites", weAdr.size() + fullCyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
